// File: rtl/segment_scanner_if.sv
// Bundles the scanner's data-side signals: enable and per-digit patterns in,
// the shared segment bus, the digit selects and the frame marker out.
interface segment_scanner_if #(
  parameter int NUM_DIGITS = 4
) ();
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    enableIn;
  logic [8*NUM_DIGITS-1:0] segmentsIn;
  logic [7:0]              segmentOut;
  logic [NUM_DIGITS-1:0]   digitSelectOut;
  logic [IDX_W-1:0]        digitIndexOut;
  logic                    frameStartOut;

  modport master (
    output enableIn, segmentsIn,
    input  segmentOut, digitSelectOut, digitIndexOut, frameStartOut
  );

  modport slave (
    input  enableIn, segmentsIn,
    output segmentOut, digitSelectOut, digitIndexOut, frameStartOut
  );
endinterface

// File: rtl/segment_scanner.sv
// Time-multiplexed seven-segment scan driver: one shared segment bus, one
// select per digit, a blanking gap at the start of every digit slot.
module segment_scanner #(
  parameter int         NUM_DIGITS       = 4,
  parameter int         DWELL_CYCLES     = 2700,
  parameter int         BLANK_CYCLES     = 270,
  parameter logic [7:0] SEGMENT_OFF      = 8'hFF,
  parameter logic       DIGIT_ACTIVE_LOW = 1'b1
) (
  input logic              clkIn,
  input logic              resetIn,
  segment_scanner_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int K_W   = $clog2(DWELL_CYCLES);
  localparam logic [K_W-1:0]        K_LAST  = K_W'(DWELL_CYCLES - 1);
  localparam logic [K_W-1:0]        K_SHOW  = K_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      I_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_e;

  state_e                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [IDX_W-1:0]      i_q, i_d;
  logic [7:0]            pattern_q, pattern_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frame_q, frame_d;
  logic [7:0]            digit_pattern [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_pattern[gi] = bus.segmentsIn[8*gi +: 8];
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      i_q       <= '0;
      pattern_q <= SEGMENT_OFF;
      seg_q     <= SEGMENT_OFF;
      sel_q     <= SEL_OFF;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
      pattern_q <= pattern_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    i_d       = i_q;
    pattern_d = pattern_q;
    seg_d     = SEGMENT_OFF;
    sel_d     = SEL_OFF;
    frame_d   = 1'b0;
    if (!bus.enableIn) begin
      state_d = ST_IDLE;
      k_d     = '0;
      i_d     = '0;
    end else begin
      if (state_q == ST_IDLE) begin
        k_d     = '0;
        i_d     = '0;
        frame_d = 1'b1;
      end else if (k_q == K_LAST) begin
        k_d = '0;
        if (i_q == I_LAST) begin
          i_d     = '0;
          frame_d = 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
      // Snapshot the digit once per slot so mid-slot input changes never tear.
      if (k_d == K_SHOW) begin
        state_d   = ST_SHOW;
        pattern_d = digit_pattern[i_d];
      end else if (k_d == '0) begin
        state_d = ST_BLANK;
      end
      if (state_d == ST_SHOW) begin
        seg_d = pattern_d;
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (i_d == IDX_W'(d)) sel_d[d] = ~DIGIT_ACTIVE_LOW;
        end
      end
    end
  end

  assign bus.segmentOut     = seg_q;
  assign bus.digitSelectOut = sel_q;
  assign bus.digitIndexOut  = i_q;
  assign bus.frameStartOut  = frame_q;
endmodule

// File: tb/tb_segment_scanner.sv
// Directed bench: DWELL=8 with BLANK=2 (dut_a) and BLANK=0 (dut_b).
module tb_segment_scanner;
  localparam int ND = 4;
  localparam int DW = 8;
  localparam logic [31:0] PATS  = {8'h03, 8'h9F, 8'h25, 8'h0D};
  localparam logic [31:0] PATS2 = {8'h03, 8'h9F, 8'h99, 8'h0D};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic mon_en = 1'b0;
  int checks = 0;
  int failures = 0;

  segment_scanner_if #(.NUM_DIGITS(ND)) bus_a ();
  segment_scanner_if #(.NUM_DIGITS(ND)) bus_b ();

  segment_scanner #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(2),
                    .SEGMENT_OFF(8'hFF), .DIGIT_ACTIVE_LOW(1'b1))
    dut_a (.clkIn(clk), .resetIn(rst_a), .bus(bus_a.slave));

  segment_scanner #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(0),
                    .SEGMENT_OFF(8'hFF), .DIGIT_ACTIVE_LOW(1'b1))
    dut_b (.clkIn(clk), .resetIn(rst_b), .bus(bus_b.slave));

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input int c, input int blank, input logic [31:0] pats,
                             input logic [7:0] seg, input logic [3:0] sel,
                             input logic [1:0] idx, input logic frame);
    int slot = c / DW;
    int k = c % DW;
    logic [7:0] exp_seg;
    logic [3:0] exp_sel;
    logic [3:0] one;
    one = 4'b0001;
    if (k < blank) begin
      exp_seg = 8'hFF;
      exp_sel = 4'hF;
    end else begin
      exp_seg = pats[8*slot +: 8];
      exp_sel = ~(one << slot);
    end
    check_value($sformatf("%s_c%0d_seg", tag, c), 32'(seg), 32'(exp_seg));
    check_value($sformatf("%s_c%0d_sel", tag, c), 32'(sel), 32'(exp_sel));
    check_value($sformatf("%s_c%0d_idx", tag, c), 32'(idx), 32'(slot));
    check_value($sformatf("%s_c%0d_frame", tag, c), 32'(frame), 32'(c == 0));
    if (k == DW - 1) $display("%s slot %0d seg=%h sel=%b", tag, slot, seg, sel);
  endtask

  task automatic check_blank_a(input string tag);
    check_value({tag, "_seg"}, 32'(bus_a.segmentOut), 32'h0000_00FF);
    check_value({tag, "_sel"}, 32'(bus_a.digitSelectOut), 32'h0000_000F);
    check_value({tag, "_idx"}, 32'(bus_a.digitIndexOut), 32'd0);
    check_value({tag, "_frame"}, 32'(bus_a.frameStartOut), 32'd0);
  endtask

  // At most one digit may ever be lit, across reset and enable edges too.
  always @(negedge clk) begin
    if (mon_en) begin
      check_value("onehot_a", 32'($countones(~bus_a.digitSelectOut) <= 1), 32'd1);
      check_value("onehot_b", 32'($countones(~bus_b.digitSelectOut) <= 1), 32'd1);
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.enableIn = 1'b1;
    bus_a.segmentsIn = PATS;
    bus_b.enableIn = 1'b1;
    bus_b.segmentsIn = PATS;

    for (int r = 0; r < 3; r++) begin
      tick();
      mon_en = 1'b1;
      check_blank_a($sformatf("reset%0d", r));
    end
    $display("reset phase done");

    rst_a = 1'b0;
    tick();
    for (int c = 0; c < 32; c++) begin
      check_cycle("f1", c, 2, PATS, bus_a.segmentOut, bus_a.digitSelectOut,
                  bus_a.digitIndexOut, bus_a.frameStartOut);
      tick();
    end

    for (int c = 0; c < 32; c++) begin
      check_cycle("f2", c, 2, PATS, bus_a.segmentOut, bus_a.digitSelectOut,
                  bus_a.digitIndexOut, bus_a.frameStartOut);
      if (c == 12) bus_a.segmentsIn[15:8] = 8'h99;
      tick();
    end

    for (int c = 0; c < 22; c++) begin
      check_cycle("f3", c, 2, PATS2, bus_a.segmentOut, bus_a.digitSelectOut,
                  bus_a.digitIndexOut, bus_a.frameStartOut);
      if (c == 21) bus_a.enableIn = 1'b0;
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      check_blank_a($sformatf("dis%0d", j));
      if (j == 4) bus_a.enableIn = 1'b1;
      tick();
    end
    $display("enable gap done");

    for (int c = 0; c < 32; c++) begin
      check_cycle("f4", c, 2, PATS2, bus_a.segmentOut, bus_a.digitSelectOut,
                  bus_a.digitIndexOut, bus_a.frameStartOut);
      tick();
    end
    for (int c = 0; c < 31; c++) begin
      check_cycle("f5", c, 2, PATS2, bus_a.segmentOut, bus_a.digitSelectOut,
                  bus_a.digitIndexOut, bus_a.frameStartOut);
      if (c == 30) rst_a = 1'b1;
      tick();
    end
    check_blank_a("midrst0");
    tick();
    check_blank_a("midrst1");
    $display("mid-show reset done");

    rst_b = 1'b0;
    tick();
    for (int c = 0; c < 64; c++) begin
      check_cycle("b", c % 32, 0, PATS, bus_b.segmentOut, bus_b.digitSelectOut,
                  bus_b.digitIndexOut, bus_b.frameStartOut);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/segment_scanner.md
# segment_scanner

Time-multiplexed scan driver for the four-digit seven-segment board. Sits directly downstream of the per-digit `display` instances. Concatenates their encoded 8-bit segment patterns and drives one shared segment bus plus one digit-select line per digit. Inserts a programmable blanking gap between digits to suppress ghosting.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits; must be ≥ 2.
- `DWELL_CYCLES`, 2700: clock cycles per digit slot, blanking included; must be ≥ 2.
- `BLANK_CYCLES`, 270: cycles at the start of each slot with all digits off; 0 ≤ `BLANK_CYCLES` < `DWELL_CYCLES`.
- `SEGMENT_OFF`, 8'hFF: `segmentOut` value while blanking. Default matches active-low segment encoding.
- `DIGIT_ACTIVE_LOW`, 1'b1: selects digit-select polarity. 1 means the selected digit is driven 0 and unselected digits 1.
- `clkIn` input 1: single clock; all logic on rising edge.
- `resetIn` input 1: synchronous, active-high reset.
- `enableIn` input 1: scan enable; low forces blank and restarts the scan.
- `segmentsIn` input 8*NUM_DIGITS: digit i pattern at bits [8i+7:8i], already encoded/polarised, passed through unmodified.
- `segmentOut` output 8: shared segment bus, registered.
- `digitSelectOut` output NUM_DIGITS: one-hot (polarity per `DIGIT_ACTIVE_LOW`) digit enables, registered.
- `digitIndexOut` output max(1,$clog2(NUM_DIGITS)): index of the current slot, registered.
- `frameStartOut` output 1: one-cycle pulse in the first cycle of slot 0, registered.

## Operation
- State: slot counter `k` (0..DWELL_CYCLES-1), digit index `i` (0..NUM_DIGITS-1), phase ∈ {BLANK, SHOW}, captured pattern register.
- Slot cycle k < BLANK_CYCLES (phase BLANK) requires:
  - `segmentOut` = `SEGMENT_OFF`.
  - All digit selects inactive.
- Slot cycle k ≥ BLANK_CYCLES (phase SHOW) requires:
  - Digit select i active, all others inactive.
  - `segmentOut` = pattern of digit i captured at the edge entering k = BLANK_CYCLES, held constant to slot end. `segmentsIn` changes mid-slot are ignored until the next slot.
- Slot end (k = DWELL_CYCLES-1):
  - k → 0, i → i+1.
  - Wrap NUM_DIGITS-1 → 0; `frameStartOut` pulses in that new k = 0 cycle.
- BLANK_CYCLES = 0: no BLANK phase. Capture occurs at the edge entering k = 0, and slots abut with no off gap.
- `digitIndexOut` = i throughout the slot, including during blanking.
- `enableIn` low (sampled at an edge) requires, from the next cycle:
  - Blank outputs.
  - k = 0, i = 0, `frameStartOut` = 0; held while low.
- `enableIn` rising: the first cycle after the sampling edge is slot 0, k = 0, with `frameStartOut` = 1.
- `resetIn` has priority over `enableIn` and is honoured in any phase, mid-slot included.
- Never more than one digit select active in any cycle, including across reset/enable transitions.

## Timing
- Reset values: `segmentOut` = `SEGMENT_OFF`, `digitSelectOut` all inactive, `digitIndexOut` = 0, `frameStartOut` = 0, k = 0, captured pattern = `SEGMENT_OFF`.
- First edge with `resetIn` low and `enableIn` high: the following cycle is slot 0, k = 0, `frameStartOut` = 1.
- Slot 0 SHOW cycles contain digit 0 pattern as sampled BLANK_CYCLES edges after scan start. Latency from `segmentsIn` change to display is at most DWELL_CYCLES·NUM_DIGITS + BLANK_CYCLES cycles.
- Frame period is exactly DWELL_CYCLES·NUM_DIGITS cycles. `frameStartOut` spacing equals the frame period.
- All outputs change only on `clkIn` rising edges; no combinational input-to-output paths.

## Test plan
- Reset/start:
  - Stimulus: hold `resetIn` 3 cycles, then release with `enableIn` = 1, DWELL = 8, BLANK = 2.
  - Required: outputs at reset values during reset. `frameStartOut` = 1 in the first post-reset cycle only. `segmentOut` = 8'hFF and `digitSelectOut` = 4'b1111 for 2 cycles, then `digitSelectOut` = 4'b1110 for 6 cycles.
- Full scan:
  - Stimulus: `segmentsIn` = {8'h03, 8'h9F, 8'h25, 8'h0D} (digits 3..0).
  - Required: SHOW phases emit 8'h0D, 8'h25, 8'h9F, 8'h03 with selects 1110, 1101, 1011, 0111. `digitIndexOut` 0..3. Second `frameStartOut` exactly 32 cycles after the first.
- Snapshot:
  - Stimulus: change digit 1 pattern 8'h25 → 8'h99 at slot 1, k = 4.
  - Required: `segmentOut` stays 8'h25 through slot 1; the next frame's slot 1 shows 8'h99.
- Enable gating:
  - Stimulus: drop `enableIn` at slot 2, k = 5, for 5 cycles, then raise.
  - Required: blank from the next cycle with index 0. On re-enable, `frameStartOut` = 1 and slot 0 restarts at k = 0.
- Reset mid-SHOW:
  - Stimulus: assert `resetIn` at slot 3, k = 6.
  - Required: next cycle all selects inactive, `segmentOut` = 8'hFF, `digitIndexOut` = 0. Never two selects active.
- BLANK_CYCLES = 0:
  - Stimulus: run the same full scan with BLANK_CYCLES = 0.
  - Required: `digitSelectOut` always exactly one active while enabled. Each digit is shown 8 consecutive cycles.
